pci_master_ctrl: RTL and testbench
==================================

PCI_MASTER_CTRL -- requirements
Module: pci_master_ctrl

Interface
REQ-001 Parameter MAX_BURST, default 8: maximum data phases per transaction, from 1 to 15.
REQ-002 Parameter DEVSEL_TIMEOUT, default 5: clocks after the address phase before master abort.
REQ-003 Port list:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request pulse from local side.
- cmd  in  4  PCI command; 0110 = memory read, 0111 = memory write.
- start_addr  in  32  first address.
- length  in  4  number of data phases, 1..MAX_BURST.
- wr_data  in  32  current write word.
- wr_data_req  out  1  pop pulse: current write word consumed.
- rd_data  out  32  captured read word.
- rd_valid  out  1  one-cycle strobe for rd_data.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- status  out  2  00 = ok, 01 = master abort, 10 = target stop.
- req  out  1  bus request, active-low.
- gnt  in  1  bus grant, active-low.
- frame_out / frame_oe  out  1/1  FRAME# drive and enable.
- irdy_out / irdy_oe  out  1/1  IRDY# drive and enable.
- frame_in, irdy_in, trdy, devsel, stop  in  1 each  sampled bus lines, active-low.
- ad_out / ad_oe / ad_in  out/out/in  32/1/32  AD bus.
- cbe_out  out  4  C/BE# lines; driven whenever ad_oe is high.

Function
REQ-004 State machine states: IDLE, BUS_REQ, ADDR, DATA, TURN.
REQ-005 IDLE:
- start high latches cmd, start_addr and length.
- Next cycle: busy=1, req=0, enter BUS_REQ.
- start while busy is ignored.
REQ-006 BUS_REQ:
- Wait for gnt=0, frame_in=1 and irdy_in=1, all sampled in the same cycle.
- Then enter ADDR.
REQ-007 ADDR, exactly one cycle:
- frame_out=0, ad_out=latched address, cbe_out=cmd, ad_oe=1, req=1.
REQ-008 DATA entry and drive:
- irdy_out=0, cbe_out=0000.
- Write: ad_oe=1, ad_out=wr_data.
- Read: ad_oe=0.
REQ-009 A data phase completes on a clock where irdy_out=0 and trdy=0 are sampled together.
- Remaining count decrements.
- Write: wr_data_req pulses.
- Read: rd_data<=ad_in and rd_valid pulses.
REQ-010 frame_out is 0 on all data phases except the last; it goes 1 on the cycle the remaining count equals 1.
REQ-011 Last data phase completes → TURN, status=00.
REQ-012 Target stop: stop=0 sampled in DATA →
- frame_out=1 immediately.
- The phase still completes if trdy=0 in the same cycle.
- Then TURN, status=10, unless that phase was the final one (status=00).
REQ-013 Master abort: devsel still 1 after DEVSEL_TIMEOUT clocks counted from the ADDR cycle →
- frame_out=1, then TURN, status=01.
- No rd_valid and no wr_data_req pulses are issued.
REQ-014 TURN:
- One cycle with frame_out=1 and irdy_out=1 driven.
- Next cycle all oe=0, done pulses, busy=0, return to IDLE.
REQ-015 Both oe enables stay 0 in IDLE and BUS_REQ, so the block never contends with another master.

Reset
REQ-016 While rst=0, outputs are held at these values, taking effect asynchronously:
- req=1, frame_out=1, irdy_out=1.
- All *_oe=0, ad_out=0, cbe_out=1111.
- busy=0, done=0, rd_valid=0, wr_data_req=0, status=00, rd_data=0.
- State machine in IDLE.
REQ-017 Reset asserted mid-transaction abandons the transaction with no done pulse; the bus is released at once.

Configuration
REQ-018 Macro PCI_MST_PARITY_EN, when defined, adds par_out/par_oe (outputs), par_in (input) and perr (output).
- par_out = even parity over ad_out and cbe_out, driven one clock after each address or write-data cycle.
- On reads, par_in is checked against the captured ad_in/cbe one clock after each completed phase.
- A mismatch pulses perr for one cycle.
REQ-019 Without PCI_MST_PARITY_EN these ports and the parity logic are absent.

Structure
REQ-020 Shared package pci_pkg holds:
- command codes;
- status codes;
- state encoding;
- MAX_BURST upper bound.
REQ-021 Sub-module pci_mst_timer is the DEVSEL timeout counter; it starts on ADDR, clears on devsel=0 and outputs a single timeout flag.

Verification
REQ-022 Write, length=4, gnt=0, devsel/trdy=0 from the first data phase → four wr_data_req pulses, frame_out=1 on phase 4, done, status=00.
REQ-023 Read, length=2, trdy delayed 3 clocks per phase → rd_valid exactly twice with ad_in values 0xA5A5_0001 and 0xA5A5_0002.
REQ-024 No devsel response, DEVSEL_TIMEOUT=5 → frame_out=1 at clock 5 after ADDR, done, status=01, zero rd_valid.
REQ-025 Stop=0 together with trdy=0 on phase 2 of 4 → two transfers, done, status=10.
REQ-026 rst=0 during DATA of write phase 3 → all oe=0 and req=1 immediately, no done; a new start then runs normally.
REQ-027 With PCI_MST_PARITY_EN, a read with corrupted par_in on phase 1 → one perr pulse one clock after that phase.

Source files
------------

// File: rtl/pci_pkg.sv
// Shared PCI master definitions: command/status codes, FSM encoding, burst limit.
// No logic; parity build option PCI_MST_PARITY_EN lives in pci_master_ctrl.
// Backpressure: n/a.
package pci_pkg;

    localparam int PCI_MAX_BURST = 15;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    localparam logic [3:0] CBE_IDLE      = 4'b1111;
    localparam logic [3:0] CBE_ALL_BYTES = 4'b0000;

    typedef enum logic [1:0] {
        STAT_OK     = 2'b00,
        STAT_MABORT = 2'b01,
        STAT_TSTOP  = 2'b10
    } pci_status_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUS_REQ = 3'd1,
        ADDR    = 3'd2,
        DATA    = 3'd3,
        TURN    = 3'd4
    } pci_state_t;

    // A zero length still moves one word; anything above the burst cap is trimmed.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int cap);
        if (len == 4'd0) return 4'd1;
        if (int'(len) > cap) return 4'(cap);
        return len;
    endfunction

endpackage

// File: rtl/pci_mst_timer.sv
// DEVSEL# watchdog: counts clocks after the address phase, flags when no target claims.
// Latency: timeout asserts in the TIMEOUT-th clock after the start cycle.
// Backpressure: none; a sampled devsel=0 disarms it until the next start.
module pci_mst_timer #(
    parameter int TIMEOUT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic devsel,
    output logic timeout
);
    import pci_pkg::*;

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;
    logic         armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (start) begin
            cnt   <= W'(1);
            armed <= 1'b1;
        end else if (armed) begin
            if (!devsel) begin
                armed <= 1'b0;
            end else if (cnt != W'(TIMEOUT)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign timeout = armed && (cnt == W'(TIMEOUT));

endmodule

// File: rtl/pci_master_ctrl.sv
// PCI bus master: one burst memory read/write per start pulse; optional parity via PCI_MST_PARITY_EN.
// Latency: BUS_REQ the clock after start, ADDR once the bus is idle+granted, done one clock after TURN.
// Backpressure: target wait states (TRDY#) stall data phases; STOP# or DEVSEL# timeout end the burst.
module pci_master_ctrl
    import pci_pkg::*;
#(
    parameter int MAX_BURST      = 8,
    parameter int DEVSEL_TIMEOUT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  cmd,
    input  logic [31:0] start_addr,
    input  logic [3:0]  length,
    input  logic [31:0] wr_data,
    output logic        wr_data_req,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic        req,
    input  logic        gnt,
    output logic        frame_out,
    output logic        frame_oe,
    output logic        irdy_out,
    output logic        irdy_oe,
    input  logic        frame_in,
    input  logic        irdy_in,
    input  logic        trdy,
    input  logic        devsel,
    input  logic        stop,
    output logic [31:0] ad_out,
    output logic        ad_oe,
    output logic [3:0]  cbe_out,
`ifdef PCI_MST_PARITY_EN
    output logic        par_out,
    output logic        par_oe,
    input  logic        par_in,
    output logic        perr,
`endif
    input  logic [31:0] ad_in
);

    localparam int BURST_CAP = (MAX_BURST < 1) ? 1 :
                               (MAX_BURST > PCI_MAX_BURST) ? PCI_MAX_BURST : MAX_BURST;

    pci_state_t  state, state_nxt;
    pci_status_t status_q, end_status;
    logic [3:0]  cmd_q;
    logic [31:0] addr_q;
    logic [3:0]  rem_q;
    logic        is_write;
    logic        phase_done;
    logic        timeout;
    logic        timer_start;

    assign is_write    = (cmd_q == CMD_MEM_WRITE);
    assign timer_start = (state == ADDR);
    assign status      = status_q;

    pci_mst_timer #(
        .TIMEOUT (DEVSEL_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (timer_start),
        .devsel  (devsel),
        .timeout (timeout)
    );

    always_comb begin
        state_nxt   = state;
        end_status  = STAT_OK;
        busy        = 1'b1;
        req         = 1'b1;
        frame_out   = 1'b1;
        frame_oe    = 1'b0;
        irdy_out    = 1'b1;
        irdy_oe     = 1'b0;
        ad_out      = '0;
        ad_oe       = 1'b0;
        cbe_out     = CBE_IDLE;
        phase_done  = 1'b0;
        wr_data_req = 1'b0;

        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = BUS_REQ;
            end
            BUS_REQ: begin
                req = 1'b0;
                if (!gnt && frame_in && irdy_in) state_nxt = ADDR;
            end
            ADDR: begin
                frame_out = 1'b0;
                frame_oe  = 1'b1;
                irdy_oe   = 1'b1;
                ad_out    = addr_q;
                ad_oe     = 1'b1;
                cbe_out   = cmd_q;
                state_nxt = DATA;
            end
            DATA: begin
                // FRAME# rises on the last phase, or as soon as no target has claimed the cycle
                frame_out   = (rem_q == 4'd1) || timeout;
                frame_oe    = 1'b1;
                irdy_out    = 1'b0;
                irdy_oe     = 1'b1;
                cbe_out     = CBE_ALL_BYTES;
                if (is_write) begin
                    ad_out = wr_data;
                    ad_oe  = 1'b1;
                end
                phase_done  = !trdy && !timeout;
                wr_data_req = phase_done && is_write;
                if (timeout) begin
                    state_nxt  = TURN;
                    end_status = STAT_MABORT;
                end else if (phase_done && rem_q == 4'd1) begin
                    state_nxt  = TURN;
                end else if (!stop) begin
                    state_nxt  = TURN;
                    end_status = STAT_TSTOP;
                end
            end
            TURN: begin
                frame_oe  = 1'b1;
                irdy_oe   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            status_q <= STAT_OK;
            cmd_q    <= CBE_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nxt;
            done     <= (state == TURN);
            rd_valid <= phase_done && !is_write;
            if (state == IDLE && start) begin
                cmd_q    <= cmd;
                addr_q   <= start_addr;
                rem_q    <= clamp_len(length, BURST_CAP);
                status_q <= STAT_OK;
            end
            if (phase_done) rem_q <= rem_q - 4'd1;
            if (phase_done && !is_write) rd_data <= ad_in;
            if (state == DATA && state_nxt == TURN) status_q <= end_status;
        end
    end

`ifdef PCI_MST_PARITY_EN
    logic par_chk;
    logic par_exp;

    // PAR trails AD by one clock on the bus, so both drive and check are registered one behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_out <= 1'b0;
            par_oe  <= 1'b0;
            par_chk <= 1'b0;
            par_exp <= 1'b0;
        end else begin
            par_out <= ^{ad_out, cbe_out};
            par_oe  <= ad_oe;
            par_chk <= phase_done && !is_write;
            par_exp <= ^{ad_in, cbe_out};
        end
    end

    assign perr = par_chk && (par_in != par_exp);
`endif

endmodule

// File: tb/tb_pci_master_ctrl.sv
// Directed bench for pci_master_ctrl: bus target model driven per clock, scenario tasks check results.
`timescale 1ns/1ps
module tb_pci_master_ctrl;
    import pci_pkg::*;

    localparam logic [31:0] WR_BASE = 32'h1000_0000;
    localparam logic [31:0] RD_BASE = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        rst, start, gnt, frame_in, irdy_in, trdy, devsel, stop;
    logic [3:0]  cmd, length;
    logic [31:0] start_addr, wr_data, ad_in;
    logic        wr_data_req, rd_valid, busy, done, req;
    logic        frame_out, frame_oe, irdy_out, irdy_oe, ad_oe;
    logic [31:0] rd_data, ad_out;
    logic [1:0]  status;
    logic [3:0]  cbe_out;
`ifdef PCI_MST_PARITY_EN
    logic        par_out, par_oe, par_in, perr;
`endif

    int errors = 0;
    int checks = 0;

    int          n_pop, addr_iter, frame_hi_k, n_perr, perr_ok;
    logic [31:0] pops[$];
    logic [31:0] rdv[$];
    logic        frame_mid, frame_last, done_seen, addr_req, rst_hit;
    logic [1:0]  done_status;
    logic [31:0] addr_ad;
    logic [3:0]  addr_cbe;
    logic [2:0]  s_oe;
    logic        s_req, s_busy;
    logic [3:0]  s_cbe;
    int          s_pop;

    always #5 clk = ~clk;

    pci_master_ctrl #(.MAX_BURST(8), .DEVSEL_TIMEOUT(5)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .start_addr(start_addr),
        .length(length), .wr_data(wr_data), .wr_data_req(wr_data_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .status(status), .req(req), .gnt(gnt), .frame_out(frame_out),
        .frame_oe(frame_oe), .irdy_out(irdy_out), .irdy_oe(irdy_oe),
        .frame_in(frame_in), .irdy_in(irdy_in), .trdy(trdy), .devsel(devsel),
        .stop(stop), .ad_out(ad_out), .ad_oe(ad_oe), .cbe_out(cbe_out),
`ifdef PCI_MST_PARITY_EN
        .par_out(par_out), .par_oe(par_oe), .par_in(par_in), .perr(perr),
`endif
        .ad_in(ad_in)
    );

    task automatic idle_inputs();
        start = 1'b0; cmd = 4'h0; start_addr = '0; length = 4'd0; wr_data = '0;
        gnt = 1'b1; frame_in = 1'b1; irdy_in = 1'b1; trdy = 1'b1; devsel = 1'b1;
        stop = 1'b1; ad_in = '0;
`ifdef PCI_MST_PARITY_EN
        par_in = 1'b0;
`endif
    endtask

    // Launches one transaction and plays the target; results land in the module-level observers.
    task automatic run_txn(input logic [3:0] c, input logic [31:0] a, input logic [3:0] len,
                           input int dly, input bit resp, input int stop_ph, input int busy_cyc,
                           input int rst_ph, input int bad_par_ph);
        int phase, w, k, cpl_ph;
        bit fin, was_cpl, in_data;
        logic [31:0] cpl_ad;
        phase = 0; w = 0; k = -1; cpl_ph = -1; fin = 0; was_cpl = 0; cpl_ad = '0;
        n_pop = 0; addr_iter = -1; frame_hi_k = -1; n_perr = 0; perr_ok = 0;
        pops.delete(); rdv.delete();
        frame_mid = 1'bx; frame_last = 1'bx; done_seen = 1'b0; done_status = 2'bxx;
        addr_req = 1'bx; addr_ad = 'x; addr_cbe = 'x; rst_hit = 1'b0;
        @(negedge clk);
        start = 1'b1; cmd = c; start_addr = a; length = len;
        @(negedge clk);
        start = 1'b0;
        for (int it = 0; it < 80 && !fin; it++) begin
            wr_data  = WR_BASE + 32'(n_pop);
            gnt      = 1'b0;
            irdy_in  = 1'b1;
            frame_in = (it < busy_cyc) ? 1'b0 : 1'b1;
            devsel = 1'b1; trdy = 1'b1; stop = 1'b1;
            ad_in  = RD_BASE + 32'(phase);
            in_data = irdy_oe && !irdy_out;
            if (in_data && resp) begin
                devsel = 1'b0;
                if (w >= dly) begin
                    trdy = 1'b0;
                    if (phase + 1 == stop_ph) stop = 1'b0;
                end
            end
`ifdef PCI_MST_PARITY_EN
            par_in = was_cpl ? ((^{cpl_ad, 4'b0000}) ^ (cpl_ph == bad_par_ph)) : 1'b0;
`endif
            if (in_data && phase == rst_ph) begin
                rst = 1'b0;
                #1;
                s_oe = {frame_oe, irdy_oe, ad_oe}; s_req = req; s_busy = busy;
                s_cbe = cbe_out; s_pop = n_pop; rst_hit = 1'b1; fin = 1;
            end else begin
                #1;
                if (k >= 0) k++;
                if (frame_oe && !frame_out && irdy_out) begin
                    k = 0; addr_iter = it; addr_ad = ad_out; addr_cbe = cbe_out; addr_req = req;
                end
                if (in_data && frame_out && frame_hi_k < 0) frame_hi_k = k;
                if (wr_data_req) begin pops.push_back(ad_out); n_pop++; end
                if (rd_valid) rdv.push_back(rd_data);
`ifdef PCI_MST_PARITY_EN
                if (perr) begin
                    n_perr++;
                    if (was_cpl && cpl_ph == bad_par_ph) perr_ok++;
                end
`endif
                was_cpl = 0;
                if (in_data && !trdy) begin
                    was_cpl = (c != CMD_MEM_WRITE); cpl_ph = phase; cpl_ad = ad_in;
                    if (phase == 0) frame_mid = frame_out;
                    if (phase + 1 == int'(len)) frame_last = frame_out;
                    phase++; w = 0;
                end else if (in_data) begin
                    w++;
                end
                if (done) begin fin = 1; done_seen = 1'b1; done_status = status; end
                if (!fin) @(negedge clk);
            end
        end
        if (bad_par_ph > 99) $display("note: parity phase %0d unused", cpl_ph);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #2;
        checks++; if (req !== 1'b1 || frame_out !== 1'b1 || irdy_out !== 1'b1) begin errors++;
            $display("FAIL reset_lines got req=%b frame=%b irdy=%b exp 1/1/1", req, frame_out, irdy_out); end
        checks++; if ({frame_oe, irdy_oe, ad_oe} !== 3'b000) begin errors++;
            $display("FAIL reset_oe got %b exp 000", {frame_oe, irdy_oe, ad_oe}); end
        checks++; if (ad_out !== 32'h0 || cbe_out !== 4'hF) begin errors++;
            $display("FAIL reset_ad got ad=%h cbe=%h exp 0/f", ad_out, cbe_out); end
        checks++; if ({busy, done, rd_valid, wr_data_req} !== 4'b0000 || status !== 2'b00 || rd_data !== 32'h0) begin
            errors++; $display("FAIL reset_flags got bdrw=%b st=%b rd=%h exp 0000/00/0",
                               {busy, done, rd_valid, wr_data_req}, status, rd_data); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0 || req !== 1'b1) begin errors++;
            $display("FAIL reset_release got busy=%b req=%b exp 0/1", busy, req); end
    endtask

    task automatic test_write();
        run_txn(CMD_MEM_WRITE, 32'h1000_0040, 4'd4, 0, 1'b1, 0, 0, -1, -1);
        checks++; if (done_seen !== 1'b1 || done_status !== STAT_OK) begin errors++;
            $display("FAIL write_done got done=%b status=%b exp 1/00", done_seen, done_status); end
        checks++; if (n_pop != 4) begin errors++;
            $display("FAIL write_pops got %0d exp 4", n_pop); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (pops[i] !== WR_BASE + 32'(i)) begin errors++;
                $display("FAIL write_word%0d got %h exp %h", i, pops[i], WR_BASE + 32'(i)); end
        end
        checks++; if (frame_mid !== 1'b0 || frame_last !== 1'b1) begin errors++;
            $display("FAIL write_frame got ph1=%b ph4=%b exp 0/1", frame_mid, frame_last); end
        checks++; if (addr_ad !== 32'h1000_0040 || addr_cbe !== 4'b0111 || addr_req !== 1'b1) begin errors++;
            $display("FAIL write_addr got ad=%h cbe=%b req=%b exp 10000040/0111/1", addr_ad, addr_cbe, addr_req); end
        checks++; if (addr_iter != 1) begin errors++;
            $display("FAIL write_addr_cycle got %0d exp 1", addr_iter); end
        checks++; if (busy !== 1'b0 || rdv.size() != 0) begin errors++;
            $display("FAIL write_end got busy=%b rdv=%0d exp 0/0", busy, rdv.size()); end
    endtask

    task automatic test_read_wait();
        run_txn(CMD_MEM_READ, 32'h2000_0000, 4'd2, 3, 1'b1, 0, 2, -1, -1);
        checks++; if (addr_iter != 3) begin errors++;
            $display("FAIL read_bus_wait got addr at %0d exp 3", addr_iter); end
        checks++; if (rdv.size() != 2) begin errors++;
            $display("FAIL read_count got %0d exp 2", rdv.size()); end
        checks++; if (rdv[0] !== 32'hA5A5_0001 || rdv[1] !== 32'hA5A5_0002) begin errors++;
            $display("FAIL read_data got %h %h exp a5a50001 a5a50002", rdv[0], rdv[1]); end
        checks++; if (done_seen !== 1'b1 || done_status !== STAT_OK || n_pop != 0) begin errors++;
            $display("FAIL read_done got done=%b status=%b pops=%0d exp 1/00/0", done_seen, done_status, n_pop); end
    endtask

    task automatic test_master_abort();
        run_txn(CMD_MEM_READ, 32'h3000_0000, 4'd4, 0, 1'b0, 0, 0, -1, -1);
        checks++; if (frame_hi_k != 5) begin errors++;
            $display("FAIL abort_frame got clock %0d exp 5", frame_hi_k); end
        checks++; if (done_seen !== 1'b1 || done_status !== STAT_MABORT) begin errors++;
            $display("FAIL abort_status got done=%b status=%b exp 1/01", done_seen, done_status); end
        checks++; if (rdv.size() != 0 || n_pop != 0) begin errors++;
            $display("FAIL abort_xfers got rdv=%0d pops=%0d exp 0/0", rdv.size(), n_pop); end
    endtask

    task automatic test_target_stop();
        run_txn(CMD_MEM_WRITE, 32'h4000_0000, 4'd4, 0, 1'b1, 2, 0, -1, -1);
        checks++; if (n_pop != 2) begin errors++;
            $display("FAIL stop_pops got %0d exp 2", n_pop); end
        checks++; if (done_seen !== 1'b1 || done_status !== STAT_TSTOP) begin errors++;
            $display("FAIL stop_status got done=%b status=%b exp 1/10", done_seen, done_status); end
    endtask

    task automatic test_reset_mid();
        int ndone;
        run_txn(CMD_MEM_WRITE, 32'h5000_0000, 4'd4, 0, 1'b1, 0, 0, 2, -1);
        checks++; if (rst_hit !== 1'b1 || s_pop != 2) begin errors++;
            $display("FAIL rstmid_reach got hit=%b pops=%0d exp 1/2", rst_hit, s_pop); end
        checks++; if (s_oe !== 3'b000 || s_req !== 1'b1 || s_busy !== 1'b0 || s_cbe !== 4'hF) begin errors++;
            $display("FAIL rstmid_release got oe=%b req=%b busy=%b cbe=%h exp 000/1/0/f", s_oe, s_req, s_busy, s_cbe); end
        idle_inputs();
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b1;
            #1;
            if (done) ndone++;
        end
        checks++; if (ndone != 0 || busy !== 1'b0) begin errors++;
            $display("FAIL rstmid_nodone got done_pulses=%0d busy=%b exp 0/0", ndone, busy); end
        run_txn(CMD_MEM_WRITE, 32'h5000_0100, 4'd2, 1, 1'b1, 0, 0, -1, -1);
        checks++; if (done_seen !== 1'b1 || done_status !== STAT_OK || n_pop != 2) begin errors++;
            $display("FAIL rstmid_recover got done=%b status=%b pops=%0d exp 1/00/2", done_seen, done_status, n_pop); end
    endtask

`ifdef PCI_MST_PARITY_EN
    task automatic test_parity();
        run_txn(CMD_MEM_READ, 32'h6000_0000, 4'd2, 0, 1'b1, 0, 0, -1, 0);
        checks++; if (n_perr != 1 || perr_ok != 1) begin errors++;
            $display("FAIL parity_perr got pulses=%0d aligned=%0d exp 1/1", n_perr, perr_ok); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_master_abort();
        test_target_stop();
        test_reset_mid();
`ifdef PCI_MST_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
